// File: rtl/fsm_mem_w_init_pkg.sv
// Shared definitions for the memory-initialisation controller: state
// encoding and default geometry of the RAM being filled.
package mem_init_pkg;

  // Default address/data width; the RAM holds 2**DEFAULT_ADDR_W entries.
  localparam int DEFAULT_ADDR_W = 8;
  localparam int MEM_DEPTH      = 2**DEFAULT_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } init_state_t;

endpackage : mem_init_pkg

// File: rtl/fsm_mem_w_init_if.sv
// Handshake and RAM write-port bundle between the sequencer, the init
// controller and the RAM. The controller is the master: it consumes
// start and drives the write port plus the finish flag.
interface fsm_mem_w_init_if
  import mem_init_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] wr_data;
  logic              finish;

  modport master (
    input  start,
    output wr_en,
    output mem_addr,
    output wr_data,
    output finish
  );

  modport slave (
    output start,
    input  wr_en,
    input  mem_addr,
    input  wr_data,
    input  finish
  );

endinterface : fsm_mem_w_init_if

// File: rtl/fsm_mem_w_init_up_counter.sv
// Free-running W-bit up counter with synchronous clear and count enable.
// It wraps naturally from all-ones to zero; at_max flags the last value so
// the owner can end a sweep on the same edge the counter wraps.
module up_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_max
);

  logic [W-1:0] count_reg;

  // Count register: clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count  = count_reg;
  assign at_max = &count_reg;

endmodule : up_counter

// File: rtl/fsm_mem_w_init.sv
// Memory-initialisation controller. On a start request it writes the
// identity pattern (address i <- value i) to every RAM location in one
// gapless ascending sweep, then raises finish and waits for start to drop
// before it can be re-armed. All outputs are Moore: decoded from the state
// register and the address counter only, never from start directly.
module fsm_mem_w_init
  import mem_init_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  fsm_mem_w_init_if.master          bus
);

  init_state_t       state_reg;
  init_state_t       state_next;
  logic [ADDR_W-1:0] i_count;
  logic              i_at_max;
  logic              cnt_clear;
  logic              cnt_en;

  // Address counter; it only advances while writing and is held at zero
  // otherwise so every sweep starts from address 0.
  up_counter #(
    .W (ADDR_W)
  ) u_addr_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .en     (cnt_en),
    .count  (i_count),
    .at_max (i_at_max)
  );

  // State register; the asynchronous reset makes the outputs drop
  // immediately because they are decoded straight from this register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and counter control. start is only looked at in IDLE and
  // DONE; dropping it mid-sweep does not abort the run.
  always_comb begin
    state_next = state_reg;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cnt_clear = 1'b1;
        if (bus.start) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        cnt_en = 1'b1;
        // The counter wraps to 0 on this same edge, leaving it clean.
        if (i_at_max) begin
          state_next = DONE;
        end
      end
      DONE: begin
        cnt_clear = 1'b1;
        // Requiring start to fall prevents an immediate re-run.
        if (!bus.start) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  // Moore output decode; address and data read 0 outside WRITE.
  always_comb begin
    bus.wr_en    = 1'b0;
    bus.mem_addr = '0;
    bus.wr_data  = '0;
    bus.finish   = 1'b0;
    unique case (state_reg)
      WRITE: begin
        bus.wr_en    = 1'b1;
        bus.mem_addr = i_count;
        bus.wr_data  = i_count;
      end
      DONE: begin
        bus.finish = 1'b1;
      end
      default: begin
        bus.wr_en = 1'b0;
      end
    endcase
  end

endmodule : fsm_mem_w_init

// File: tb/tb_fsm_mem_w_init.sv
// Directed bench for fsm_mem_w_init: reset values, full sweeps, the finish
// handshake, start dropped mid-run, asynchronous reset mid-run and re-run.
// A RAM model records every committed write for content and
// write-once checks.
module tb_fsm_mem_w_init;
  import mem_init_pkg::*;

  localparam int AW = DEFAULT_ADDR_W;

  logic clk;
  logic rst;

  int total;
  int bad;

  // RAM scoreboard state.
  logic [AW-1:0] sb_ram [MEM_DEPTH];
  int            sb_cnt [MEM_DEPTH];
  int            sb_writes;
  logic          sb_clear;

  fsm_mem_w_init_if #(.ADDR_W(AW)) bus ();

  fsm_mem_w_init #(
    .ADDR_W (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: commits a write on each rising edge where wr_en is high.
  always @(posedge clk) begin
    if (sb_clear) begin
      for (int a = 0; a < MEM_DEPTH; a++) begin
        sb_ram[a] = 'x;
        sb_cnt[a] = 0;
      end
      sb_writes = 0;
    end else if (bus.wr_en === 1'b1) begin
      sb_ram[bus.mem_addr] = bus.wr_data;
      sb_cnt[bus.mem_addr] = sb_cnt[bus.mem_addr] + 1;
      sb_writes = sb_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".wr_en"},    32'(bus.wr_en),    32'd0);
    check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, ".wr_data"},  32'(bus.wr_data),  32'd0);
    check({tag, ".finish"},   32'(bus.finish),   32'd0);
  endtask

  // Called at the negedge after E0; walks the 256 write cycles and ends
  // at the negedge following the last committing edge. drop_at >= 0
  // lowers start while that address is being written.
  task automatic run_sweep(input string tag, input int drop_at);
    for (int k = 0; k < MEM_DEPTH; k++) begin
      check({tag, ".wr_en"},    32'(bus.wr_en),    32'd1);
      check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(k));
      check({tag, ".wr_data"},  32'(bus.wr_data),  32'(k));
      check({tag, ".finish"},   32'(bus.finish),   32'd0);
      if (k == drop_at) bus.start = 1'b0;
      @(negedge clk);
    end
    $display("sweep %s: %0d write cycles walked", tag, MEM_DEPTH);
  endtask

  task automatic check_ram(input string tag);
    for (int k = 0; k < MEM_DEPTH; k++) begin
      check({tag, ".ram"},  32'(sb_ram[k]), 32'(k));
      check({tag, ".once"}, 32'(sb_cnt[k]), 32'd1);
    end
    check({tag, ".writes"}, 32'(sb_writes), 32'(MEM_DEPTH));
    $display("ram %s: contents and write counts checked", tag);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    sb_clear  = 1'b1;
    sb_writes = 0;
    rst       = 1'b0;
    bus.start = 1'b1;

    // Reset held with start high; outputs must be all zero.
    #1 rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");
    $display("reset: outputs checked while rst high");
    rst      = 1'b0;
    sb_clear = 1'b0;

    // E0 moves to WRITE; the second edge after release commits address 0.
    @(negedge clk);
    run_sweep("run1", -1);

    // DONE with start still high: finish held, no further writes.
    for (int c = 0; c < 20; c++) begin
      check("done_hold.finish", 32'(bus.finish), 32'd1);
      check("done_hold.wr_en",  32'(bus.wr_en),  32'd0);
      check("done_hold.addr",   32'(bus.mem_addr), 32'd0);
      @(negedge clk);
    end
    check_ram("run1");
    $display("done hold: 20 cycles with start high checked");

    // Drop start for two cycles; the first edge returns to IDLE.
    bus.start = 1'b0;
    sb_clear  = 1'b1;
    @(negedge clk);
    check_idle_outputs("rearm");
    sb_clear = 1'b0;
    @(negedge clk);
    check_idle_outputs("rearm2");
    bus.start = 1'b1;
    @(negedge clk);

    // Second sweep, start dropped at address 100: run still completes.
    run_sweep("run2", 100);
    check("run2_done.finish", 32'(bus.finish), 32'd1);
    check("run2_done.wr_en",  32'(bus.wr_en),  32'd0);
    @(negedge clk);
    check_idle_outputs("run2_idle");
    check_ram("run2");

    // Third run interrupted by async reset between edges at address 50.
    bus.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 50; k++) @(negedge clk);
    check("pre_rst.addr",  32'(bus.mem_addr), 32'd50);
    check("pre_rst.wr_en", 32'(bus.wr_en),    32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    $display("async reset: outputs checked before next edge");
    sb_clear = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_held");
    rst      = 1'b0;
    sb_clear = 1'b0;
    @(negedge clk);
    run_sweep("run3", -1);
    check("run3_done.finish", 32'(bus.finish), 32'd1);
    check_ram("run3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fsm_mem_w_init
